// File: rtl/dsp_ctrl_sequencer_if.sv
// Decode-to-sequencer handshake and the stage-aligned DSP48E1 control bundle.
// The master side is the decode stage; the slave side is the sequencer.
interface dsp_ctrl_sequencer_if #(
   parameter int CNT_W = 4,
   parameter int OPC_W = 5
);
   logic             op_valid;
   logic             op_ready;
   logic [OPC_W-1:0] opcode;
   logic [CNT_W-1:0] op_repeat;
   logic             stall;
   logic [4:0]       inmode_exe1;
   logic             cep_exe1;
   logic [6:0]       opmode_exe2;
   logic [3:0]       alumode_exe2;
   logic             carryin_exe2;
   logic             result_valid;
   logic             busy;

   modport master (
      output op_valid, opcode, op_repeat, stall,
      input  op_ready, inmode_exe1, cep_exe1, opmode_exe2, alumode_exe2,
             carryin_exe2, result_valid, busy
   );

   modport slave (
      input  op_valid, opcode, op_repeat, stall,
      output op_ready, inmode_exe1, cep_exe1, opmode_exe2, alumode_exe2,
             carryin_exe2, result_valid, busy
   );
endinterface

// File: rtl/dsp_ctrl_sequencer.sv
// Issue sequencer for the DSP48E1 EXE1/EXE2 stages: decodes ALU opcodes,
// expands MAC into repeated accumulate slots and tracks result availability.
module dsp_ctrl_sequencer #(
   parameter int CNT_W = 4,
   parameter int OPC_W = 5
) (
   input  logic i_clk,
   input  logic i_rst_n,
   dsp_ctrl_sequencer_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_ACCUM = 2'd2;

   localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_MUL    = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_MAC    = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_MULADD = OPC_W'(5);

   localparam logic [4:0] IM_AB  = 5'b00000;
   localparam logic [4:0] IM_MUL = 5'b10001;
   localparam logic [6:0] OM_CAB = 7'b0110011;
   localparam logic [6:0] OM_M   = 7'b0000101;
   localparam logic [6:0] OM_PM  = 7'b0100101;
   localparam logic [6:0] OM_CM  = 7'b0110101;

   // One control word as it travels EXE1 -> EXE2; last marks the slot that completes an op.
   typedef struct packed {
      logic       vld;
      logic [4:0] inmode;
      logic [6:0] opmode;
      logic [3:0] alumode;
      logic       cin;
      logic       last;
   } ctl_t;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   ctl_t [1:0]       r_stg;
   logic             r_res_vld;

   logic w_ready, w_xfer, w_mac_long;
   ctl_t w_dec, w_iss;

   assign w_ready    = i_rst_n && !bus.stall && (r_state == S_IDLE || r_state == S_ISSUE);
   assign w_xfer     = bus.op_valid && w_ready;
   assign w_mac_long = (bus.opcode == OP_MAC) && (bus.op_repeat != '0);

   always_comb begin
      w_dec = '0;
      case (bus.opcode)
         OP_ADD:    begin w_dec.vld = 1'b1; w_dec.inmode = IM_AB; w_dec.opmode = OM_CAB; end
         OP_SUB:    begin w_dec.vld = 1'b1; w_dec.inmode = IM_AB; w_dec.opmode = OM_CAB;
                          w_dec.alumode = 4'b0011; end
         OP_MUL,
         OP_MAC:    begin w_dec.vld = 1'b1; w_dec.inmode = IM_MUL; w_dec.opmode = OM_M; end
         OP_MULADD: begin w_dec.vld = 1'b1; w_dec.inmode = IM_MUL; w_dec.opmode = OM_CM; end
         default:   ;
      endcase
      w_dec.last = !w_mac_long;
   end

   // ACCUM owns the issue slot; otherwise a transferred opcode issues directly.
   always_comb begin
      w_iss = '0;
      if (r_state == S_ACCUM) begin
         w_iss.vld    = 1'b1;
         w_iss.inmode = IM_MUL;
         w_iss.opmode = OM_PM;
         w_iss.last   = (r_cnt <= CNT_W'(1));
      end else if (w_xfer) begin
         w_iss = w_dec;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_stg     <= '0;
         r_res_vld <= 1'b0;
      end else if (!bus.stall) begin
         r_stg[0]  <= w_iss;
         r_stg[1]  <= r_stg[0];
         r_res_vld <= r_stg[1].vld && r_stg[1].last;
         case (r_state)
            S_IDLE, S_ISSUE: begin
               if (w_xfer && w_mac_long) begin
                  r_state <= S_ACCUM;
                  r_cnt   <= bus.op_repeat;
               end else if (w_xfer) begin
                  r_state <= S_ISSUE;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ACCUM: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt <= CNT_W'(1)) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.op_ready     = w_ready;
   assign bus.inmode_exe1  = r_stg[0].inmode;
   assign bus.cep_exe1     = r_stg[0].vld && !bus.stall;
   assign bus.opmode_exe2  = r_stg[1].opmode;
   assign bus.alumode_exe2 = r_stg[1].alumode;
   assign bus.carryin_exe2 = r_stg[1].cin;
   assign bus.result_valid = r_res_vld;
   assign bus.busy         = (r_state != S_IDLE) || r_stg[0].vld || r_stg[1].vld;
endmodule

// File: doc/dsp_ctrl_sequencer.md
Name: dsp_ctrl_sequencer

Overview:
- Controller for the DSP48E1-based execution stages (EXE1/EXE2) of the streaming IPPro datapath.
- Accepts decoded ALU opcodes from the decode stage over a valid/ready handshake.
- Sequences single-cycle and multi-cycle (MAC accumulate) operations.
- Drives stage-aligned DSP48E1 control fields (INMODE/CEP at EXE1; OPMODE/ALUMODE/CARRYIN at EXE2) and flags result availability at the P register.

Parameters:
- CNT_W, 4, width of the MAC repeat count (max accumulate length 2^CNT_W).
- OPC_W, 5, opcode width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- OP_VALID  input  1  opcode presented by decode stage.
- OP_READY  output  1  sequencer accepts opcode this cycle.
- OPCODE  input  OPC_W  operation select (table below).
- OP_REPEAT  input  CNT_W  MAC only: number of extra accumulate cycles (0 = single multiply-load).
- STALL  input  1  downstream back-pressure; freezes the sequencer.
- INMODE_EXE1  output  5  DSP48E1 INMODE for EXE1.
- CEP_EXE1  output  1  P-register clock enable for EXE1.
- OPMODE_EXE2  output  7  DSP48E1 OPMODE for EXE2.
- ALUMODE_EXE2  output  4  DSP48E1 ALUMODE for EXE2.
- CARRYIN_EXE2  output  1  DSP48E1 CARRYIN for EXE2.
- RESULT_VALID  output  1  P output holds a completed result.
- BUSY  output  1  any operation is in flight in the sequencer or its stages.

Behaviour:
- Reset, asynchronous on RST_N low:
  - all outputs 0 except OP_READY.
  - OP_READY = 1 after reset release; it is 0 while RST_N is low.
  - state = IDLE, counter = 0, all stage valid bits cleared.
  - A reset mid-MAC aborts the operation; no RESULT_VALID is produced for it.
- Opcode table (INMODE / OPMODE / ALUMODE / CARRYIN):
  - NOP=0: 00000 / 0000000 / 0000 / 0; CEP = 0.
  - ADD=1: 00000 / 0110011 / 0000 / 0 (C + A:B).
  - SUB=2: 00000 / 0110011 / 0011 / 0 (C − A:B).
  - MUL=3: 10001 / 0000101 / 0000 / 0 (A×B).
  - MAC=4:
    - first cycle: 10001 / 0000101 / 0000 / 0 (load product).
    - each repeat cycle: 10001 / 0100101 / 0000 / 0 (P + A×B).
  - MULADD=5: 10001 / 0110101 / 0000 / 0 (C + A×B).
  - Any other value is treated as NOP.
- Handshake:
  - An opcode transfers when OP_VALID && OP_READY on a rising edge.
  - OP_READY = !STALL && (state == IDLE || state == ISSUE).
  - OP_READY is combinational from STALL and registered state.
- State machine:
  - IDLE:
    - MAC transfer with OP_REPEAT > 0 → ACCUM; counter = OP_REPEAT.
    - any other transfer → ISSUE.
    - no transfer → stay in IDLE.
  - ISSUE: one op issued this cycle.
    - new non-MAC transfer (or MAC with OP_REPEAT = 0) → stay in ISSUE; back-to-back ops at one per cycle.
    - MAC transfer with OP_REPEAT > 0 → ACCUM.
    - no transfer → IDLE.
  - ACCUM:
    - OP_READY = 0; issues one accumulate control word per unstalled cycle and decrements the counter.
    - counter reaching 1 with the issue → IDLE.
    - A MAC with OP_REPEAT = R occupies exactly R+1 issue slots.
- Pipeline timing:
  - Transfer at edge t drives INMODE_EXE1/CEP_EXE1 registered at t+1.
  - OPMODE/ALUMODE/CARRYIN_EXE2 registered at t+2.
  - RESULT_VALID = 1 at t+3 for one cycle per completed op.
  - For MAC, RESULT_VALID is asserted only after the final accumulate slot, not the intermediate ones.
  - NOP produces no RESULT_VALID and CEP_EXE1 = 0.
- CEP_EXE1 = 1 in any EXE1 slot holding a non-NOP op; otherwise 0.
- STALL:
  - While high, every stage register, the state and the counter hold their values.
  - CEP_EXE1 is forced to 0 combinationally so the P register does not advance.
  - RESULT_VALID holds its value.
  - On release, sequencing resumes with no slot lost or duplicated.
- BUSY = (state != IDLE) || any stage valid bit set.
- Counter is CNT_W bits with no wrap: OP_REPEAT = 2^CNT_W−1 gives 2^CNT_W slots, counting down to 0.
- STALL asserted in the same cycle as OP_VALID: no transfer, because OP_READY = 0.

Test Plan:
- Reset release, then ADD on cycle 1 → INMODE_EXE1 = 00000 and CEP_EXE1 = 1 at cycle 2; OPMODE_EXE2 = 0110011 and ALUMODE_EXE2 = 0000 at cycle 3; RESULT_VALID pulses at cycle 4; BUSY low by cycle 5.
- Back-to-back SUB, MUL, MULADD on cycles 1–3 → OP_READY stays 1; ALUMODE_EXE2 = 0011 at cycle 3; OPMODE_EXE2 sequence 0110011, 0000101, 0110101 on cycles 3–5; three RESULT_VALID pulses on cycles 4–6.
- MAC with OP_REPEAT = 3 → OP_READY = 0 for 3 cycles; OPMODE_EXE2 = 0000101 then 0100101 ×3; exactly one RESULT_VALID, 3 cycles after the last issue slot.
- STALL held 2 cycles in the middle of MAC with OP_REPEAT = 2 → CEP_EXE1 = 0 and all outputs frozen during the stall; total accumulate slots still 3; single RESULT_VALID, delayed by 2 cycles.
- Unknown OPCODE = 17 → treated as NOP: CEP_EXE1 = 0, OPMODE_EXE2 = 0000000, no RESULT_VALID.
- RST_N pulsed low during ACCUM with the counter at 2 → all outputs 0 immediately; after release, OP_READY = 1, BUSY = 0, no RESULT_VALID.
